// File: rtl/sphere3_sched_pkg.sv
// sphere3_sched_pkg: shared state encoding and datapath widths for the point-generator scheduler
package sphere3_sched_pkg;
  typedef enum logic [1:0] {IDLE, POP, RESEED, DONE} sched_state_e;
  localparam int COORD_W = 32;
  localparam int SEED_W = 32;
endpackage

// File: rtl/sphere3_sched_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit of req_i searching upward from ptr_i with wrap
//   req_i : request vector
//   ptr_i : highest-priority index
//   gnt_o : one-hot winner (zero when req_i is zero)
//   idx_o : winner index
module rr_pick #(
  parameter int N = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);
  logic [PW:0] s;
  logic found;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, ptr_i} + (PW+1)'(i);
      s = (s >= (PW+1)'(N)) ? s - (PW+1)'(N) : s;
      if (!found && req_i[s[PW-1:0]]) begin
        found = 1'b1;
        gnt_o[s[PW-1:0]] = 1'b1;
        idx_o = s[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/sphere3_sched.sv
// sphere3_sched: round-robin sharing of one sphere3 point generator among NUM_REQ requesters
//   req_i/req_reseed_i/req_seed_i : per-requester request level, type (1 = reseed) and seed
//   gnt_o/done_o/err_o            : one-hot pulses for accept, success, pop timeout
//   pt_*_o                        : last captured point, valid while done_o pulses
//   busy_o                        : scheduler not idle
//   gen_*                         : generator controls out, valid and coordinates in
module sphere3_sched
  import sphere3_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_reseed_i,
  input  logic [NUM_REQ*SEED_W-1:0] req_seed_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [COORD_W-1:0]        pt_w_o,
  output logic [COORD_W-1:0]        pt_x_o,
  output logic [COORD_W-1:0]        pt_y_o,
  output logic [COORD_W-1:0]        pt_z_o,
  output logic                      busy_o,
  output logic                      gen_pop_enable_o,
  output logic                      gen_reseed_enable_o,
  output logic [SEED_W-1:0]         gen_seed_o,
  input  logic                      gen_valid_i,
  input  logic [COORD_W-1:0]        gen_w_i,
  input  logic [COORD_W-1:0]        gen_x_i,
  input  logic [COORD_W-1:0]        gen_y_i,
  input  logic [COORD_W-1:0]        gen_z_i
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  sched_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, cur_q, cur_d, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt, gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [COORD_W-1:0] w_q, w_d, x_q, x_d, y_q, y_d, z_q, z_d;
  logic [SEED_W-1:0] seed_q, seed_d, pick_seed;
  logic [TW-1:0] tmo_q, tmo_d;
  logic busy_q, pop_q, pop_d, rs_q, rs_d, gv_q, rise;
  // a level that was already high when POP began is a stale point, only a fresh rise counts
  assign rise = gen_valid_i & ~gv_q;
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx)
  );
  always_comb begin
    pick_seed = '0;
    for (int i = 0; i < NUM_REQ; i++)
      pick_seed = (pick_idx == PW'(i)) ? req_seed_i[i*SEED_W +: SEED_W] : pick_seed;
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cur_d = cur_q;
    gnt_d = '0;
    done_d = '0;
    err_d = '0;
    w_d = w_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    seed_d = seed_q;
    tmo_d = tmo_q;
    pop_d = 1'b0;
    rs_d = 1'b0;
    case (state_q)
      IDLE: if (|req_i) begin
        cur_d = pick_idx;
        gnt_d = pick_gnt;
        tmo_d = '0;
        rs_d = req_reseed_i[pick_idx];
        pop_d = ~req_reseed_i[pick_idx];
        state_d = rs_d ? RESEED : POP;
        seed_d = rs_d ? pick_seed : seed_q;
      end
      RESEED: begin
        state_d = DONE;
        done_d[cur_q] = 1'b1;
      end
      POP: if (rise) begin
        state_d = DONE;
        done_d[cur_q] = 1'b1;
        w_d = gen_w_i;
        x_d = gen_x_i;
        y_d = gen_y_i;
        z_d = gen_z_i;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = DONE;
        err_d[cur_q] = 1'b1;
      end else begin
        pop_d = 1'b1;
        tmo_d = tmo_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d = (cur_q == PW'(NUM_REQ - 1)) ? '0 : cur_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cur_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      err_q <= '0;
      w_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      seed_q <= '0;
      tmo_q <= '0;
      busy_q <= 1'b0;
      pop_q <= 1'b0;
      rs_q <= 1'b0;
      gv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cur_q <= cur_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      err_q <= err_d;
      w_q <= w_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      seed_q <= seed_d;
      tmo_q <= tmo_d;
      busy_q <= (state_d != IDLE);
      pop_q <= pop_d;
      rs_q <= rs_d;
      gv_q <= gen_valid_i;
    end
  end
  assign gnt_o = gnt_q;
  assign done_o = done_q;
  assign err_o = err_q;
  assign pt_w_o = w_q;
  assign pt_x_o = x_q;
  assign pt_y_o = y_q;
  assign pt_z_o = z_q;
  assign busy_o = busy_q;
  assign gen_pop_enable_o = pop_q;
  assign gen_reseed_enable_o = rs_q;
  assign gen_seed_o = seed_q;
endmodule

// File: tb/tb_sphere3_sched.sv
// tb_sphere3_sched: randomized and directed checking of sphere3_sched against an event-time model
module tb_sphere3_sched;
  localparam int N = 4;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0, req_reseed = '0;
  logic [N*32-1:0] req_seed = '0;
  logic [N-1:0] gnt, done, err;
  logic [31:0] pt_w, pt_x, pt_y, pt_z, gen_seed;
  logic [31:0] gen_w = '0, gen_x = '0, gen_y = '0, gen_z = '0;
  logic busy, gen_pop, gen_rs;
  logic gen_valid = 1'b0;
  int errors = 0, checks = 0;
  bit gen_auto = 1'b0, req_auto = 1'b0;
  int ord[8];
  int nord;

  always #5 clk = ~clk;

  sphere3_sched #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .req_reseed_i(req_reseed), .req_seed_i(req_seed),
    .gnt_o(gnt), .done_o(done), .err_o(err),
    .pt_w_o(pt_w), .pt_x_o(pt_x), .pt_y_o(pt_y), .pt_z_o(pt_z),
    .busy_o(busy), .gen_pop_enable_o(gen_pop), .gen_reseed_enable_o(gen_rs),
    .gen_seed_o(gen_seed), .gen_valid_i(gen_valid),
    .gen_w_i(gen_w), .gen_x_i(gen_x), .gen_y_i(gen_y), .gen_z_i(gen_z)
  );

  // Model: tracks each transaction by the edge numbers at which its events fall.
  typedef struct packed {
    int e, next_arb, pop_start, w, rr, rs_edge;
    bit pop_act, rs_pend, prev_v;
    logic [N-1:0] gnt, done, err;
    logic pop, rs, busy;
    logic [31:0] seed, pw, px, py, pz;
  } mst_t;
  mst_t m = '0;

  function automatic mst_t step(mst_t s);
    int j;
    if (rst) return '0;
    s.gnt = '0; s.done = '0; s.err = '0; s.pop = 1'b0; s.rs = 1'b0;
    if (s.pop_act) begin
      if (gen_valid && !s.prev_v) begin
        s.done = N'(1 << s.w);
        s.pw = gen_w; s.px = gen_x; s.py = gen_y; s.pz = gen_z;
        s.pop_act = 1'b0; s.next_arb = s.e + 2;
      end else if (s.e - s.pop_start == TMO) begin
        s.err = N'(1 << s.w);
        s.pop_act = 1'b0; s.next_arb = s.e + 2;
      end else s.pop = 1'b1;
    end
    if (s.rs_pend && s.e == s.rs_edge + 1) begin
      s.done = N'(1 << s.w);
      s.rs_pend = 1'b0;
    end
    if (!s.pop_act && !s.rs_pend && s.e >= s.next_arb && req != '0) begin
      for (int i = N - 1; i >= 0; i--) begin
        j = (s.rr + i) % N;
        if (req[j]) s.w = j;
      end
      s.rr = (s.w + 1) % N;
      s.gnt = N'(1 << s.w);
      if (req_reseed[s.w]) begin
        s.rs = 1'b1; s.seed = req_seed[s.w*32 +: 32];
        s.rs_pend = 1'b1; s.rs_edge = s.e; s.next_arb = s.e + 3;
      end else begin
        s.pop = 1'b1; s.pop_act = 1'b1; s.pop_start = s.e;
      end
    end
    s.busy = s.pop_act || s.rs_pend || (s.e + 1 < s.next_arb);
    s.prev_v = gen_valid;
    s.e++;
    return s;
  endfunction

  always @(posedge clk) m <= step(m);

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  function automatic int oh2i(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rst) begin
      chk("rst_gnt", 32'(gnt), 0); chk("rst_done", 32'(done), 0); chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0); chk("rst_pop", 32'(gen_pop), 0); chk("rst_rs", 32'(gen_rs), 0);
      chk("rst_seed", gen_seed, 0); chk("rst_pt_w", pt_w, 0); chk("rst_pt_x", pt_x, 0);
      chk("rst_pt_y", pt_y, 0); chk("rst_pt_z", pt_z, 0);
    end else begin
      chk("gnt", 32'(gnt), 32'(m.gnt)); chk("done", 32'(done), 32'(m.done)); chk("err", 32'(err), 32'(m.err));
      chk("busy", 32'(busy), 32'(m.busy)); chk("pop_en", 32'(gen_pop), 32'(m.pop));
      chk("reseed_en", 32'(gen_rs), 32'(m.rs)); chk("seed", gen_seed, m.seed);
      chk("pt_w", pt_w, m.pw); chk("pt_x", pt_x, m.px); chk("pt_y", pt_y, m.py); chk("pt_z", pt_z, m.pz);
    end
    req = req & ~(done | err);
    if (gen_auto) begin
      if ($urandom_range(0, 3) == 0) gen_valid = ~gen_valid;
      gen_w = $urandom; gen_x = $urandom; gen_y = $urandom; gen_z = $urandom;
    end
    if (req_auto)
      for (int i = 0; i < N; i++)
        if (!req[i] && !(done[i] | err[i]) && $urandom_range(0, 5) == 0) begin
          req_reseed[i] = ($urandom_range(0, 2) == 0);
          req_seed[i*32 +: 32] = $urandom;
          req[i] = 1'b1;
        end
  endtask

  task automatic wait_gnt(string n);
    int k = 0;
    do begin tick(); k++; end while (gnt == '0 && k < 20);
    if (gnt == '0) begin
      checks++; errors++;
      $display("FAIL %s: no grant within 20 cycles", n);
    end
  endtask

  task automatic settle();
    int k = 0;
    while ((req != '0 || busy) && k < 300) begin tick(); k++; end
    if (req != '0 || busy) begin
      checks++; errors++;
      $display("FAIL settle: still busy, req=%b busy=%b", req, busy);
    end
  endtask

  task automatic collect(int upto);
    for (int k = 0; k < 80 && nord < upto; k++) begin
      tick();
      if (gnt != '0) begin ord[nord] = oh2i(gnt); nord++; end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ord[i] = -1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", 32'(busy), 0);
    // fairness: all four held, then 1001 twice
    req_reseed = '1;
    req_seed = {$urandom, $urandom, $urandom, $urandom};
    req = '1;
    nord = 0;
    collect(4);
    chk("fair0", ord[0], 0); chk("fair1", ord[1], 1); chk("fair2", ord[2], 2); chk("fair3", ord[3], 3);
    settle();
    nord = 0;
    req = 4'b1001; collect(2); settle();
    req = 4'b1001; collect(4); settle();
    chk("pair0", ord[0], 0); chk("pair1", ord[1], 3); chk("pair2", ord[2], 0); chk("pair3", ord[3], 3);
    // single pop
    req_reseed = '0;
    req = 4'b0001;
    wait_gnt("pop");
    chk("pop_gnt", 32'(gnt), 1); chk("pop_busy", 32'(busy), 1); chk("pop_en_on", 32'(gen_pop), 1);
    repeat (6) tick();
    gen_w = 32'hA0A0_0001; gen_x = 32'hA0A0_0002; gen_y = 32'hA0A0_0003; gen_z = 32'hA0A0_0004;
    gen_valid = 1'b1;
    tick();
    chk("pop_done", 32'(done), 1); chk("pop_pt_w", pt_w, 32'hA0A0_0001); chk("pop_pt_z", pt_z, 32'hA0A0_0004);
    chk("pop_en_off", 32'(gen_pop), 0);
    tick();
    chk("pop_idle", 32'(busy), 0);
    settle();
    gen_valid = 1'b0;
    // reseed from requester 2
    req_reseed = 4'b0100;
    req_seed[95:64] = 32'h0000_0005;
    req = 4'b0100;
    wait_gnt("reseed");
    chk("rs_gnt", 32'(gnt), 4); chk("rs_en", 32'(gen_rs), 1); chk("rs_seed", gen_seed, 5);
    tick();
    chk("rs_done", 32'(done), 4); chk("rs_en_off", 32'(gen_rs), 0); chk("rs_seed_hold", gen_seed, 5);
    settle();
    // valid already high on POP entry
    req_reseed = '0;
    gen_w = 32'h5555_0001; gen_x = 32'h5555_0002; gen_y = 32'h5555_0003; gen_z = 32'h5555_0004;
    gen_valid = 1'b1;
    repeat (2) tick();
    req = 4'b0001;
    wait_gnt("stuck");
    chk("stuck_gnt", 32'(gnt), 1);
    tick();
    gen_valid = 1'b0;
    repeat (3) tick();
    chk("stuck_nodone", 32'(done), 0);
    gen_w = 32'h7777_0001; gen_x = 32'h7777_0002; gen_y = 32'h7777_0003; gen_z = 32'h7777_0004;
    gen_valid = 1'b1;
    tick();
    chk("stuck_done", 32'(done), 1); chk("stuck_pt_w", pt_w, 32'h7777_0001); chk("stuck_pt_x", pt_x, 32'h7777_0002);
    settle();
    // timeout, then the next requester is served
    gen_valid = 1'b0;
    req = 4'b0001;
    wait_gnt("tmo");
    chk("tmo_gnt", 32'(gnt), 1);
    req_reseed[1] = 1'b1;
    req_seed[63:32] = 32'h0000_00AB;
    req[1] = 1'b1;
    begin
      int n = 0;
      do begin tick(); n++; end while (err == '0 && n < 40);
      chk("tmo_cycles", n, 16);
    end
    chk("tmo_err", 32'(err), 1); chk("tmo_pt_w", pt_w, 32'h7777_0001);
    repeat (2) tick();
    chk("tmo_next", 32'(gnt), 2);
    settle();
    // reset in the middle of a pop
    req_reseed = '0;
    req = 4'b0001;
    wait_gnt("rstpop");
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0); chk("midrst_pop", 32'(gen_pop), 0); chk("midrst_seed", gen_seed, 0);
    req = '0;
    repeat (2) tick();
    rst = 1'b0;
    req = 4'b0001;
    wait_gnt("postrst");
    chk("postrst_gnt", 32'(gnt), 1);
    tick();
    gen_w = 32'hBEEF_0001; gen_x = 32'hBEEF_0002; gen_y = 32'hBEEF_0003; gen_z = 32'hBEEF_0004;
    gen_valid = 1'b1;
    tick();
    chk("postrst_done", 32'(done), 1); chk("postrst_pt_w", pt_w, 32'hBEEF_0001);
    settle();
    gen_valid = 1'b0;
    // random traffic
    gen_auto = 1'b1;
    req_auto = 1'b1;
    repeat (1500) tick();
    req_auto = 1'b0;
    settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
